// File: rtl/bsg_mem_1rw_sync_tiled_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bsg_mem_1rw_sync_tiled_pkg
// Brief    : Clear-FSM states, grid geometry helpers and hardened macro list
// Revision : 1.0
// ============================================================================
package bsg_mem_1rw_sync_tiled_pkg;

    typedef enum logic [0:0] {
        eCLEAR = 1'b0,
        eREADY = 1'b1
    } state_e;

    typedef struct packed {
        int els;
        int bits;
        int mux;
    } macro_t;

    localparam int c_num_macros = 3;
    localparam macro_t c_macros [c_num_macros] = '{
        '{els: 64,  bits: 32, mux: 1},
        '{els: 256, bits: 32, mux: 2},
        '{els: 512, bits: 64, mux: 4}
    };

    function automatic int num_cols(input int width, input int tile_width);
        return (width + tile_width - 1) / tile_width;
    endfunction

    function automatic int num_rows(input int els, input int tile_els);
        return els / tile_els;
    endfunction

    function automatic int row_sel_width(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

    function automatic int mask_width(input int width);
        return (width + 7) / 8;
    endfunction

    function automatic bit macro_match(input int els, input int bits);
        for (int i = 0; i < c_num_macros; i++) begin
            if (c_macros[i].els == els && c_macros[i].bits == bits) begin
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bsg_mem_1rw_sync_tile.sv
`default_nettype none
// ============================================================================
// Module   : bsg_mem_1rw_sync_tile
// Brief    : One bit-masked 1rw sync RAM tile; hardened macro or synthesised model
// Revision : 1.0
// ============================================================================
module bsg_mem_1rw_sync_tile
    import bsg_mem_1rw_sync_tiled_pkg::*;
#(
    parameter int width_p  = 32,
    parameter int els_p    = 64,
    parameter bit harden_p = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     v_i,
    input  logic                     w_i,
    input  logic [$clog2(els_p)-1:0] addr_i,
    input  logic [width_p-1:0]       data_i,
    input  logic [width_p-1:0]       w_mask_i,
    output logic [width_p-1:0]       data_o
);

    generate
        if (harden_p && macro_match(els_p, width_p)) begin : g_macro
            // Macro pins are all active-low: chip enable, global write enable, bit write enables.
            logic               w_cen;
            logic               w_gwen;
            logic [width_p-1:0] w_wen;
            logic [width_p-1:0] r_mem [els_p];
            logic [width_p-1:0] r_q;

            assign w_cen  = ~v_i;
            assign w_gwen = ~w_i;
            assign w_wen  = ~w_mask_i;

            always_ff @(posedge clk_i) begin
                if (!w_cen) begin
                    if (!w_gwen) begin
                        r_mem[addr_i] <= (r_mem[addr_i] & w_wen) | (data_i & ~w_wen);
                    end else begin
                        r_q <= r_mem[addr_i];
                    end
                end
            end

            assign data_o = r_q;
        end else begin : g_synth
            logic [width_p-1:0] r_mem [els_p];
            logic [width_p-1:0] r_q;

            always_ff @(posedge clk_i) begin
                if (v_i) begin
                    if (w_i) begin
                        r_mem[addr_i] <= (r_mem[addr_i] & ~w_mask_i) | (data_i & w_mask_i);
                    end else begin
                        r_q <= r_mem[addr_i];
                    end
                end
            end

            assign data_o = r_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/bsg_mem_1rw_sync_tiled.sv
`default_nettype none
// ============================================================================
// Module   : bsg_mem_1rw_sync_tiled
// Brief    : Tiled 1rw sync RAM with byte mask, read-data hold and clear engine
// Revision : 1.0
// ============================================================================
module bsg_mem_1rw_sync_tiled
    import bsg_mem_1rw_sync_tiled_pkg::*;
#(
    parameter int                 width_p          = 32,
    parameter int                 els_p            = 64,
    parameter int                 tile_width_p     = 32,
    parameter int                 tile_els_p       = 64,
    parameter bit                 mask_p           = 1'b1,
    parameter bit                 clear_on_reset_p = 1'b1,
    parameter logic [width_p-1:0] clear_val_p      = '0,
    parameter bit                 harden_p         = 1'b1
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           v_i,
    input  logic                           w_i,
    input  logic [$clog2(els_p)-1:0]       addr_i,
    input  logic [width_p-1:0]             data_i,
    input  logic [mask_width(width_p)-1:0] w_mask_i,
    input  logic                           clear_i,
    output logic                           ready_o,
    output logic [width_p-1:0]             data_o
);

    localparam int c_cols    = num_cols(width_p, tile_width_p);
    localparam int c_rows    = num_rows(els_p, tile_els_p);
    localparam int c_row_w   = row_sel_width(c_rows);
    localparam int c_tile_aw = $clog2(tile_els_p);
    localparam int c_grid_w  = c_cols * tile_width_p;
    localparam logic [c_tile_aw-1:0] c_clr_last  = c_tile_aw'(tile_els_p - 1);
    localparam state_e               c_rst_state = clear_on_reset_p ? eCLEAR : eREADY;

    state_e                  r_state, w_state_nxt;
    logic [c_tile_aw-1:0]    r_clr_cnt, w_clr_cnt_nxt;
    logic                    r_ready, r_read_pending;
    logic [c_row_w-1:0]      r_row, w_row;
    logic [width_p-1:0]      r_hold, w_row_data;
    logic [c_grid_w-1:0]     w_bit_mask, w_tile_data, w_tile_mask;
    logic [c_tile_aw-1:0]    w_tile_addr;
    logic                    w_tile_w, w_access, w_read;
    logic [c_rows-1:0]       w_row_v;
    logic [tile_width_p-1:0] w_q [c_rows][c_cols];

    generate
        if (c_rows > 1) begin : g_row_sel
            assign w_row = addr_i[$clog2(els_p)-1:c_tile_aw];
        end else begin : g_row_fixed
            assign w_row = '0;
        end
    endgenerate

    // A clear request takes priority over an access presented in the same cycle.
    assign w_access = r_ready & v_i & ~clear_i;
    assign w_read   = w_access & ~w_i;

    always_comb begin
        w_bit_mask = '1;
        for (int i = 0; i < width_p; i++) begin
            w_bit_mask[i] = mask_p ? w_mask_i[i / 8] : 1'b1;
        end
    end

    // Padding bits of the last column are always written with zero.
    always_comb begin
        w_tile_addr = addr_i[c_tile_aw-1:0];
        w_tile_data = c_grid_w'(data_i);
        w_tile_mask = w_bit_mask;
        w_tile_w    = w_i;
        w_row_v     = '0;
        if (r_state == eCLEAR) begin
            w_tile_addr = r_clr_cnt;
            w_tile_data = c_grid_w'(clear_val_p);
            w_tile_mask = '1;
            w_tile_w    = 1'b1;
            w_row_v     = '1;
        end else begin
            for (int r = 0; r < c_rows; r++) begin
                w_row_v[r] = w_access && (w_row == c_row_w'(r));
            end
        end
    end

    generate
        for (genvar r = 0; r < c_rows; r++) begin : g_row
            for (genvar c = 0; c < c_cols; c++) begin : g_col
                bsg_mem_1rw_sync_tile #(
                    .width_p  (tile_width_p),
                    .els_p    (tile_els_p),
                    .harden_p (harden_p)
                ) u_tile (
                    .clk_i    (clk_i),
                    .v_i      (w_row_v[r]),
                    .w_i      (w_tile_w),
                    .addr_i   (w_tile_addr),
                    .data_i   (w_tile_data[c*tile_width_p +: tile_width_p]),
                    .w_mask_i (w_tile_mask[c*tile_width_p +: tile_width_p]),
                    .data_o   (w_q[r][c])
                );
            end
        end
    endgenerate

    always_comb begin
        w_row_data = '0;
        for (int i = 0; i < width_p; i++) begin
            w_row_data[i] = w_q[r_row][i / tile_width_p][i % tile_width_p];
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        case (r_state)
            eCLEAR: begin
                w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                if (r_clr_cnt == c_clr_last) begin
                    w_state_nxt   = eREADY;
                    w_clr_cnt_nxt = '0;
                end
            end
            eREADY: begin
                if (clear_i) begin
                    w_state_nxt   = eCLEAR;
                    w_clr_cnt_nxt = '0;
                end
            end
            default: w_state_nxt = eCLEAR;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state        <= c_rst_state;
            r_clr_cnt      <= '0;
            r_ready        <= ~clear_on_reset_p;
            r_row          <= '0;
            r_read_pending <= 1'b0;
            r_hold         <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_clr_cnt      <= w_clr_cnt_nxt;
            r_ready        <= (w_state_nxt == eREADY);
            r_read_pending <= w_read;
            if (w_read) begin
                r_row <= w_row;
            end
            if (r_read_pending) begin
                r_hold <= w_row_data;
            end
        end
    end

    assign ready_o = r_ready;
    assign data_o  = r_read_pending ? w_row_data : r_hold;

    a_no_access_when_busy: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(v_i && !ready_o))
        else $warning("bsg_mem_1rw_sync_tiled: v_i driven while ready_o is low");

endmodule
`default_nettype wire

// File: tb/tb_bsg_mem_1rw_sync_tiled.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsg_mem_1rw_sync_tiled
// Brief    : Two geometries (32x64 macro, 46x1024 synthesised) against an array model
// Revision : 1.0
// ============================================================================
module tb_bsg_mem_1rw_sync_tiled;

    localparam logic [45:0] C_CLR_B = 46'h1234_5678_9ABC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v, w, clear;
    logic [9:0]  addr;
    logic [45:0] data;
    logic [5:0]  mask;
    logic        ready_a, ready_b;
    logic [31:0] dout_a;
    logic [45:0] dout_b;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    bsg_mem_1rw_sync_tiled #(
        .width_p(32), .els_p(64), .clear_val_p(32'h0), .harden_p(1'b1)
    ) dut_a (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v), .w_i(w), .addr_i(addr[5:0]),
        .data_i(data[31:0]), .w_mask_i(mask[3:0]), .clear_i(clear),
        .ready_o(ready_a), .data_o(dout_a)
    );

    bsg_mem_1rw_sync_tiled #(
        .width_p(46), .els_p(1024), .clear_val_p(C_CLR_B), .harden_p(1'b0)
    ) dut_b (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v), .w_i(w), .addr_i(addr),
        .data_i(data), .w_mask_i(mask), .clear_i(clear),
        .ready_o(ready_b), .data_o(dout_b)
    );

    // Reference: plain arrays, a busy-cycle count and the last value read.
    logic [31:0] mem_a [64];
    logic [45:0] mem_b [1024];
    int          busy;
    logic [31:0] exp_a;
    logic [45:0] exp_b;
    logic        exp_ready;
    assign exp_ready = (busy == 0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  = 64;
            exp_a = '0;
            exp_b = '0;
        end else if (busy > 0) begin
            busy = busy - 1;
            if (busy == 0) begin
                for (int i = 0; i < 64; i++) mem_a[i] = '0;
                for (int i = 0; i < 1024; i++) mem_b[i] = C_CLR_B;
            end
        end else if (clear) begin
            busy = 64;
        end else if (v && w) begin
            for (int i = 0; i < 32; i++) if (mask[i / 8]) mem_a[addr % 64][i] = data[i];
            for (int i = 0; i < 46; i++) if (mask[i / 8]) mem_b[addr][i] = data[i];
        end else if (v) begin
            exp_a = mem_a[addr % 64];
            exp_b = mem_b[addr];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready_a", 64'(ready_a), 64'(exp_ready));
            check("ready_b", 64'(ready_b), 64'(exp_ready));
            check("data_a", 64'(dout_a), 64'(exp_a));
            check("data_b", 64'(dout_b), 64'(exp_b));
        end
    end

    task automatic do_write(input logic [9:0] a, input logic [45:0] d, input logic [5:0] m);
        @(negedge clk);
        v = 1'b1; w = 1'b1; addr = a; data = d; mask = m; clear = 1'b0;
        @(negedge clk);
        v = 1'b0; w = 1'b0;
    endtask

    task automatic do_read(input logic [9:0] a);
        @(negedge clk);
        v = 1'b1; w = 1'b0; addr = a; clear = 1'b0;
        @(negedge clk);
        v = 1'b0;
    endtask

    task automatic read_all();
        for (int i = 0; i < 64; i++) do_read(10'(i + 64 * (i % 16)));
    endtask

    task automatic edges_to_ready(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ready_a !== 1'b1 && n < 200);
    endtask

    initial begin
        int n;
        rst_n = 1'b1; v = 1'b0; w = 1'b0; clear = 1'b0; addr = '0; data = '0; mask = '0;
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data_a", 64'(dout_a), 64'h0);
        check("rst_ready_a", 64'(ready_a), 64'h0);
        rst_n = 1'b1;
        edges_to_ready(n);
        check("rst_clear_len", 64'(n), 64'd64);

        read_all();
        check("clr_val_a", 64'(dout_a), 64'h0);
        check("clr_val_b", 64'(dout_b), 64'(C_CLR_B));

        do_write(10'd5, 46'h3C0_DEADBEEF, 6'h3F);
        do_read(10'd5);
        check("rd5_a", 64'(dout_a), 64'hDEADBEEF);
        check("rd5_b", 64'(dout_b), 64'h3C0_DEADBEEF);
        repeat (10) @(negedge clk);
        do_write(10'd6, 46'h1, 6'h3F);
        repeat (2) @(negedge clk);
        check("hold_a", 64'(dout_a), 64'hDEADBEEF);

        do_write(10'd1023, 46'h1, 6'b111111);
        do_read(10'd1023);
        check("rd1023_b", 64'(dout_b), 64'h1);
        do_read(10'd63);
        check("rd63_b", 64'(dout_b), 64'(C_CLR_B));

        do_write(10'd7, 46'h1122_3344, 6'h3F);
        do_write(10'd7, 46'hAABB_CCDD, 6'b000101);
        do_read(10'd7);
        check("mask_a", 64'(dout_a), 64'h11BB_33DD);
        check("mask_b", 64'(dout_b), 64'h11BB_33DD);

        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            clear = exp_ready && ($urandom_range(0, 199) == 0);
            v     = exp_ready && $urandom_range(0, 1) == 1;
            w     = $urandom_range(0, 1) == 1;
            addr  = 10'(($urandom_range(0, 15) << 6) | $urandom_range(0, 7));
            data  = {14'($urandom), $urandom};
            mask  = 6'($urandom);
        end
        @(negedge clk);
        v = 1'b0; clear = 1'b0;
        for (int k = 0; k < 200 && !exp_ready; k++) @(negedge clk);

        do_write(10'd9, 46'h155_5555_5555, 6'h3F);
        do_write(10'd2, 46'h2A5_DEADBEEF, 6'h3F);
        do_read(10'd2);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n = 0;
        while (ready_a !== 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
            v = (n == 40) || (n == 50);
            w = (n == 40);
            addr = (n == 40) ? 10'd9 : 10'd2;
            data = 46'h3FF_0000_1234;
            mask = 6'h3F;
        end
        v = 1'b0;
        check("clear_len", 64'(n), 64'd64);
        check("hold_clear_a", 64'(dout_a), 64'hDEADBEEF);
        read_all();
        do_read(10'd9);
        check("rd9_a", 64'(dout_a), 64'h0);
        check("rd9_b", 64'(dout_b), 64'(C_CLR_B));

        do_write(10'd2, 46'h2A5_DEADBEEF, 6'h3F);
        do_read(10'd2);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (19) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_data_a", 64'(dout_a), 64'h0);
        check("midrst_data_b", 64'(dout_b), 64'h0);
        check("midrst_ready", 64'(ready_a), 64'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        edges_to_ready(n);
        check("midrst_clear_len", 64'(n), 64'd64);
        read_all();

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
